// File: rtl/sort_pkg.sv
// Shared definitions for the sort loader and its key buffer.
// Optional feature macro: SORT_LOADER_PAD_EN (short batches padded with PAD_KEY).
package sort_pkg;
   localparam int KEY_W  = 16;
   localparam int N_PROC = 8;
   localparam int N_KEYS = 16;
   localparam int IDX_W  = $clog2(N_KEYS);

   // All-ones pad value sorts above every real unsigned key.
   localparam logic [KEY_W-1:0] PAD_KEY = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_FILL = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3
`ifdef SORT_LOADER_PAD_EN
      ,
      ST_PAD  = 3'd4
`endif
   } loader_state_t;
endpackage

// File: rtl/sort_key_buffer.sv
// N_KEYS x KEY_W key register file with a single write port and a flat
// read-out laid out as the sorting array's packed init words: processor i
// sees {key[2i], key[2i+1]} in bits [32*i +: 32].
module sort_key_buffer
   import sort_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [KEY_W-1:0]        wr_data,
   output logic [N_KEYS*KEY_W-1:0] init_bus
);

   logic [KEY_W-1:0] mem [N_KEYS];

   // Key storage: cleared by reset so an aborted batch leaves no stale keys.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < N_KEYS; j++) begin
            mem[j] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Even keys land in the upper half of their processor word, odd keys in the lower half.
   for (genvar k = 0; k < N_KEYS; k++) begin : g_pack
      localparam int POS = (k % 2 == 0) ? k + 1 : k - 1;
      assign init_bus[POS*KEY_W +: KEY_W] = mem[k];
   end

endmodule

// File: rtl/sort_loader.sv
// Batch loader for the sorting array: collects N_KEYS keys over a
// valid/ready stream, pulses the array's active-low reset to load them,
// then times a fixed sort window and raises done until acknowledged.
// Optional feature macro: SORT_LOADER_PAD_EN (in_last ends a short batch,
// remaining slots are filled with PAD_KEY).
//
// Handshake: a key transfers on a rising edge where in_valid && in_ready are
// both high; in_ready is only high in FILL, and upstream must hold in_valid
// and in_key stable until the transfer happens.
module sort_loader
   import sort_pkg::*;
#(
   parameter int SORT_CYCLES = 256
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [KEY_W-1:0]        in_key,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   output logic [N_KEYS*KEY_W-1:0] init_bus,
   output logic                    array_reset,
   output logic                    busy,
   output logic                    done,
   input  logic                    done_ack,
   output loader_state_t           state_dbg
);

   loader_state_t    state;
   loader_state_t    state_nx;
   logic [IDX_W:0]   wr_idx;
   logic [15:0]      run_cnt;
   logic             accept;
   logic             last_slot;
   logic             wr_en;
   logic [KEY_W-1:0] wr_data;
   logic             in_ready_nx;
   logic             array_reset_nx;
   logic             busy_nx;
   logic             done_nx;

   assign accept    = (state == ST_FILL) && in_valid && in_ready;
   assign last_slot = (wr_idx == (IDX_W+1)'(N_KEYS - 1));
   assign state_dbg = state;

`ifndef SORT_LOADER_PAD_EN
   // Without padding support the end-of-batch marker has no effect.
   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_FILL;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_FILL: begin
            if (accept) begin
               if (last_slot) begin
                  state_nx = ST_LOAD;
               end
`ifdef SORT_LOADER_PAD_EN
               else if (in_last) begin
                  state_nx = ST_PAD;
               end
`endif
            end
         end
`ifdef SORT_LOADER_PAD_EN
         ST_PAD: begin
            if (last_slot) begin
               state_nx = ST_LOAD;
            end
         end
`endif
         ST_LOAD: state_nx = ST_RUN;
         ST_RUN: begin
            if (run_cnt == 16'(SORT_CYCLES - 1)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            if (done_ack) begin
               state_nx = ST_FILL;
            end
         end
         default: state_nx = ST_FILL;
      endcase
   end

   // Buffer write port: accepted keys in FILL, pad keys in PAD.
   always_comb begin
      wr_en   = accept;
      wr_data = in_key;
`ifdef SORT_LOADER_PAD_EN
      if (state == ST_PAD) begin
         wr_en   = 1'b1;
         wr_data = PAD_KEY;
      end
`endif
   end

   // Output decode from the next state, registered below so every output is a flop.
   always_comb begin
      in_ready_nx    = (state_nx == ST_FILL);
      array_reset_nx = (state_nx != ST_LOAD);
      busy_nx        = (state_nx == ST_RUN);
      done_nx        = (state_nx == ST_DONE);
   end

   // Output registers: in_ready and array_reset are held low during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready    <= 1'b0;
         array_reset <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         in_ready    <= in_ready_nx;
         array_reset <= array_reset_nx;
         busy        <= busy_nx;
         done        <= done_nx;
      end
   end

   // Write index: advances on each buffer write, rewinds when the batch is acknowledged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_idx <= '0;
      end else if ((state == ST_DONE) && done_ack) begin
         wr_idx <= '0;
      end else if (wr_en) begin
         wr_idx <= wr_idx + 1'b1;
      end
   end

   // Sort window counter: cleared in LOAD, counts every RUN cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= '0;
      end else if (state == ST_LOAD) begin
         run_cnt <= '0;
      end else if (state == ST_RUN) begin
         run_cnt <= run_cnt + 16'd1;
      end
   end

   sort_key_buffer u_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx[IDX_W-1:0]),
      .wr_data  (wr_data),
      .init_bus (init_bus)
   );

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: reset values, full-rate batch, gapped
// batch, mid-RUN reset, held done_ack, and in_last handling for the build
// selected by SORT_LOADER_PAD_EN.
`timescale 1ns/1ps
module tb_sort_loader;
   import sort_pkg::*;

   localparam int SC = 256;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [KEY_W-1:0]        in_key = '0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic                    in_last = 1'b0;
   logic [N_KEYS*KEY_W-1:0] init_bus;
   logic                    array_reset;
   logic                    busy;
   logic                    done;
   logic                    done_ack = 1'b0;
   loader_state_t           state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [KEY_W-1:0] kv [16];
   logic [KEY_W-1:0] exp_q [$];

   // Clock / reset
   always #5 clk = ~clk;

   sort_loader #(.SORT_CYCLES(SC)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_key      (in_key),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .init_bus    (init_bus),
      .array_reset (array_reset),
      .busy        (busy),
      .done        (done),
      .done_ack    (done_ack),
      .state_dbg   (state_dbg)
   );

   // Expected init words built from kv: processor i = {kv[2i], kv[2i+1]}.
   function automatic logic [255:0] pack_kv();
      logic [255:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         b[32*i +: 32] = {kv[2*i], kv[2*i+1]};
      end
      return b;
   endfunction

   // Key j as seen in a packed init bus.
   function automatic logic [15:0] slot(input logic [255:0] b, input int j);
      int pos;
      pos = (j % 2 == 0) ? j + 1 : j - 1;
      return b[pos*16 +: 16];
   endfunction

   // Drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a key and hold it until it transfers; leaves in_valid high.
   task automatic push_key(input logic [15:0] k, input logic last);
      int guard;
      guard    = 0;
      in_key   = k;
      in_last  = last;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 40) begin
         tick();
         guard++;
      end
      if (guard >= 40) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
      end
      tick();
      in_last = 1'b0;
   endtask

   // From the LOAD cycle, step until done; reports elapsed cycles, busy cycles, array_reset-low cycles.
   task automatic run_to_done(output int cyc, output int busy_cyc, output int rst_lo);
      cyc      = 0;
      busy_cyc = 0;
      rst_lo   = 0;
      while (done !== 1'b1 && cyc < SC + 50) begin
         tick();
         cyc++;
         if (busy === 1'b1) busy_cyc++;
         if (array_reset === 1'b0) rst_lo++;
      end
   endtask

   // Tests
   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (array_reset !== 1'b0) begin n_fail++; $display("FAIL rst_array_reset: got %b want 0", array_reset); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (init_bus !== '0) begin n_fail++; $display("FAIL rst_init_bus: got %h want 0", init_bus); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (array_reset !== 1'b1) begin n_fail++; $display("FAIL rel_array_reset: got %b want 1", array_reset); end
      n_cmp++; if (state_dbg !== ST_FILL) begin n_fail++; $display("FAIL rel_state: got %0d want %0d", state_dbg, ST_FILL); end
   endtask

   task automatic test_full_stream();
      int cyc, bcyc, rlo;
      kv = '{16'd15, 16'd14, 16'd10, 16'd13, 16'd12, 16'd11, 16'd9, 16'd8,
             16'd7, 16'd6, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd5};
      for (int i = 0; i < 16; i++) push_key(kv[i], 1'b0);
      // Keep valid high with a junk key: nothing may be taken outside FILL.
      in_key = 16'hBEEF;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_drop: got %b want 0", in_ready); end
      n_cmp++; if (array_reset !== 1'b0) begin n_fail++; $display("FAIL full_load_pulse: got %b want 0", array_reset); end
      n_cmp++; if (init_bus[31:0] !== 32'h000F000E) begin n_fail++; $display("FAIL full_word0: got %h want 000f000e", init_bus[31:0]); end
      n_cmp++; if (init_bus[255:224] !== 32'h00000005) begin n_fail++; $display("FAIL full_word7: got %h want 00000005", init_bus[255:224]); end
      n_cmp++; if (init_bus !== pack_kv()) begin n_fail++; $display("FAIL full_bus: got %h want %h", init_bus, pack_kv()); end
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL full_done_latency: got %0d want %0d", cyc, SC + 1); end
      n_cmp++; if (bcyc !== SC) begin n_fail++; $display("FAIL full_busy_cycles: got %0d want %0d", bcyc, SC); end
      n_cmp++; if (rlo !== 0) begin n_fail++; $display("FAIL full_load_width: extra low cycles %0d want 0", rlo); end
      repeat (2) tick();
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done_hold: got %b want 1", done); end
      n_cmp++; if (init_bus !== pack_kv()) begin n_fail++; $display("FAIL full_bus_stable: got %h want %h", init_bus, pack_kv()); end
      in_valid = 1'b0;
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_ack_done: got %b want 0", done); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ack_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_random_gaps();
      int cyc, bcyc, rlo;
      logic [15:0] e;
      for (int i = 0; i < 16; i++) begin
         kv[i] = 16'(i * 16'h1357 + 16'h0042);
         exp_q.push_back(kv[i]);
         push_key(kv[i], 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_key   = 16'($urandom);
            repeat ($urandom_range(1, 2)) tick();
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL gap_ready_drop: got %b want 0", in_ready); end
      for (int j = 0; j < 16; j++) begin
         e = exp_q.pop_front();
         n_cmp++; if (slot(init_bus, j) !== e) begin n_fail++; $display("FAIL gap_slot%0d: got %h want %h", j, slot(init_bus, j), e); end
      end
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL gap_done_latency: got %0d want %0d", cyc, SC + 1); end
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
   endtask

   task automatic test_mid_run_reset();
      int cyc, bcyc, rlo;
      for (int i = 0; i < 16; i++) kv[i] = 16'hA000 + 16'(i);
      for (int i = 0; i < 16; i++) push_key(kv[i], 1'b0);
      in_valid = 1'b0;
      repeat (101) tick();   // run_cnt now 100
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      reset = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
      n_cmp++; if (init_bus !== '0) begin n_fail++; $display("FAIL mid_bus: got %h want 0", init_bus); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      repeat (2) tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready: got %b want 1", in_ready); end
      repeat (5) tick();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b want 0", done); end
      for (int i = 0; i < 16; i++) kv[i] = 16'h0F00 - 16'(i * 3);
      for (int i = 0; i < 16; i++) push_key(kv[i], 1'b0);
      in_valid = 1'b0;
      n_cmp++; if (init_bus !== pack_kv()) begin n_fail++; $display("FAIL mid_new_bus: got %h want %h", init_bus, pack_kv()); end
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL mid_new_latency: got %0d want %0d", cyc, SC + 1); end
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
   endtask

   task automatic test_done_ack_held();
      int cyc, bcyc, rlo;
      for (int i = 0; i < 16; i++) kv[i] = 16'h7700 ^ 16'(i * 16'h0101);
      for (int i = 0; i < 16; i++) push_key(kv[i], 1'b0);
      in_valid = 1'b0;
      done_ack = 1'b1;
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL ack_latency: got %0d want %0d", cyc, SC + 1); end
      n_cmp++; if (bcyc !== SC) begin n_fail++; $display("FAIL ack_busy_cycles: got %0d want %0d", bcyc, SC); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ack_pulse_width: got %b want 0", done); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ack_fill_ready: got %b want 1", in_ready); end
      n_cmp++; if (state_dbg !== ST_FILL) begin n_fail++; $display("FAIL ack_state: got %0d want %0d", state_dbg, ST_FILL); end
      done_ack = 1'b0;
   endtask

`ifdef SORT_LOADER_PAD_EN
   task automatic test_pad();
      int cyc, bcyc, rlo, pad_cyc;
      for (int i = 0; i < 16; i++) kv[i] = (i < 5) ? 16'h0030 + 16'(i) : 16'hFFFF;
      for (int i = 0; i < 5; i++) push_key(kv[i], (i == 4));
      in_valid = 1'b0;
      n_cmp++; if (state_dbg !== ST_PAD) begin n_fail++; $display("FAIL pad_enter: got %0d want %0d", state_dbg, ST_PAD); end
      pad_cyc = 0;
      while (array_reset !== 1'b0 && pad_cyc < 40) begin
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pad_in_ready: got %b want 0", in_ready); end
         tick();
         pad_cyc++;
      end
      n_cmp++; if (pad_cyc !== 11) begin n_fail++; $display("FAIL pad_cycles: got %0d want 11", pad_cyc); end
      n_cmp++; if (init_bus !== pack_kv()) begin n_fail++; $display("FAIL pad_bus: got %h want %h", init_bus, pack_kv()); end
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL pad_latency: got %0d want %0d", cyc, SC + 1); end
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
   endtask
`else
   task automatic test_in_last_ignored();
      int cyc, bcyc, rlo;
      for (int i = 0; i < 16; i++) kv[i] = 16'h0100 + 16'(i * 7);
      for (int i = 0; i < 16; i++) begin
         push_key(kv[i], (i == 3));
         if (i == 3) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL last_ign_ready: got %b want 1", in_ready); end
            n_cmp++; if (state_dbg !== ST_FILL) begin n_fail++; $display("FAIL last_ign_state: got %0d want %0d", state_dbg, ST_FILL); end
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (array_reset !== 1'b0) begin n_fail++; $display("FAIL last_ign_load: got %b want 0", array_reset); end
      n_cmp++; if (init_bus !== pack_kv()) begin n_fail++; $display("FAIL last_ign_bus: got %h want %h", init_bus, pack_kv()); end
      run_to_done(cyc, bcyc, rlo);
      n_cmp++; if (cyc !== SC + 1) begin n_fail++; $display("FAIL last_ign_latency: got %0d want %0d", cyc, SC + 1); end
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
   endtask
`endif

   // Sequence and final report
   initial begin
      test_reset();
      test_full_stream();
      test_random_gaps();
      test_mid_run_reset();
      test_done_ack_held();
`ifdef SORT_LOADER_PAD_EN
      test_pad();
`else
      test_in_last_ignored();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sort_loader.md
# sort_loader

Upstream feeder for `sorting_engine`. It accepts a stream of 16-bit keys over a valid/ready handshake and buffers one 16-key batch, two keys per processor across 8 processors. It presents the batch as the engines' packed `initval` words, then pulses the array's active-low reset to load it. It counts a fixed sort window and flags completion, so batches can be sorted back-to-back without hard-coded init values.

## Interface
- `N_KEYS`, 16: keys per batch; must equal 2 × processor count.
- `KEY_W`, 16: key width in bits.
- `SORT_CYCLES`, 256: cycles the array runs after load before `done` asserts; range 1..65535.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_key`  in  KEY_W  key data.
- `in_valid`  in  1  `in_key` valid.
- `in_ready`  out  1  loader accepts a key this cycle.
- `in_last`  in  1  marks the final key of a short batch (see Configuration).
- `init_bus`  out  N_KEYS*KEY_W  packed init words; processor i's word is `init_bus[32*i +: 32]` = {key[2i], key[2i+1]}.
- `array_reset`  out  1  active-low reset to the sorting array.
- `busy`  out  1  batch loaded and sort window running.
- `done`  out  1  sort window elapsed; held until acknowledged.
- `done_ack`  in  1  releases `done`, returns to FILL.

## Operation
- States: FILL, PAD, LOAD, RUN, DONE. Reset state is FILL.
- FILL:
  - `in_ready`=1.
  - On `in_valid && in_ready`, write `in_key` to slot `wr_idx` and increment `wr_idx` (5 bits).
  - On acceptance of slot N_KEYS-1, go to LOAD.
  - Accepted `in_last` with `wr_idx` < N_KEYS-1 goes to PAD (macro only).
- PAD:
  - `in_ready`=0.
  - Write PAD_KEY (all ones) into slot `wr_idx`, one slot per cycle, until slot N_KEYS-1 is written, then go to LOAD.
- LOAD:
  - `array_reset`=0 for exactly one cycle; `init_bus` is stable.
  - Next state RUN; the 16-bit `run_cnt` clears to 0.
- RUN:
  - `busy`=1; `run_cnt` increments each cycle.
  - At `run_cnt`==SORT_CYCLES-1, go to DONE.
- DONE:
  - `done`=1, `busy`=0.
  - `done_ack` clears `wr_idx` and returns to FILL.
  - `done_ack` outside DONE is ignored.
- `init_bus` changes only on FILL/PAD writes, so it is stable from LOAD through DONE.
- `in_key` is unsigned; PAD_KEY sorts to the top so that padding is never interleaved with real keys.
- Reset mid-operation:
  - All state returns to FILL with `wr_idx`=0.
  - Any partial batch is discarded and buffer contents become all zeros.
  - No `done` is emitted for the aborted batch.

## Timing
- Reset values:
  - `in_ready`=0 while `reset` is low, 1 in the first cycle after release.
  - `array_reset`=0 while `reset` is low.
  - `busy`=0, `done`=0, `init_bus`=0.
- All outputs are registered; `in_ready` decodes the registered state only.
- A key accepted on edge k is visible in `init_bus` after edge k.
- Full-batch latency:
  - Last key accepted at edge k gives `array_reset` low in cycle k+1.
  - `busy` is high for cycles k+2 .. k+1+SORT_CYCLES.
  - `done` goes high at cycle k+2+SORT_CYCLES.
- Simultaneous `in_valid` and state exit: the key accepted on the exit edge is the last one. No key is accepted in LOAD/RUN/DONE; the upstream must hold `in_valid` and data.
- `done_ack` in DONE: FILL is entered on the next edge, with `in_ready`=1 that cycle.

## Configuration
- `SORT_LOADER_PAD_EN` defined:
  - `in_last` is honoured and the PAD state exists.
  - `in_last` on the slot N_KEYS-1 key is equivalent to a normal full batch.
- Macro undefined:
  - `in_last` is ignored and the PAD state is not compiled.
  - The loader always waits for N_KEYS keys.

## Structure
- Shared package `sort_pkg` holds:
  - `KEY_W`, `N_PROC`=8, `N_KEYS`=16, PAD_KEY=16'hFFFF.
  - The `loader_state_t` enum.
- One sub-module, `sort_key_buffer`:
  - N_KEYS×KEY_W register file.
  - Single write port (index, data, write enable) and asynchronous-reset clear.
  - Flat packed read-out in `init_bus` order.
- The FSM, `wr_idx` and `run_cnt` live in `sort_loader`.

## Test plan
- Stream keys 15,14,10,13,...,0,5 with `in_valid` held high. Expect:
  - `in_ready` drops after the 16th key.
  - `array_reset` low for one cycle.
  - `init_bus[31:0]`=32'h000F000E, `init_bus[255:224]`=32'h00000005.
  - `done` after exactly SORT_CYCLES+1 cycles following the LOAD cycle.
- Random `in_valid` gaps (50% duty) over 16 keys. Expect the same packing and no lost or duplicated keys.
- PAD_EN build, 5 keys then `in_last`. Expect:
  - 11 PAD cycles, then slots 5..15 = 16'hFFFF.
  - `array_reset` pulse immediately after the last pad write.
- Assert `reset` low mid-RUN (`run_cnt`=100). Expect:
  - `busy`=0, `done`=0, `init_bus`=0.
  - `in_ready`=1 the cycle after release.
  - A new batch loads correctly.
- Hold `done_ack` high through the whole RUN. Expect:
  - Ignored until DONE, then a one-cycle `done` pulse.
  - FILL entered on the following edge.
- Non-PAD build with `in_last` on key 3. Expect loading to continue until the 16th key, with no padding.
